multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 opcode  input  6  IR[31:26]; stable outside FETCH because IR loads only in FETCH.
REQ-004 mem_ready  input  1  memory completes the current access this cycle.
REQ-005 PCWrite  output  1  unconditional PC load.
REQ-006 PCWriteCond  output  1  PC load qualified by ALU zero.
REQ-007 IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-008 MemRead / MemWrite / IRWrite / RegWrite  output  1 each  strobes.
REQ-009 MemtoReg  output  1  writeback data select: 0 = ALUOut, 1 = MDR.
REQ-010 RegDst  output  1  destination register select: 0 = rt, 1 = rd.
REQ-011 ALUSrcA  output  1  ALU A select: 0 = PC, 1 = rs.
REQ-012 ALUSrcB  output  2  ALU B select: 00 = rt, 01 = 4, 10 = extended imm, 11 = sign-ext imm<<2.
REQ-013 ExtOp  output  1  immediate extension: 0 = sign-extend, 1 = zero-extend.
REQ-014 ALUOp  output  2  00 = add, 01 = sub, 10 = funct decode, 11 = OR.
REQ-015 PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-016 state  output  4  current state encoding.
REQ-017 instr_done  output  1  one-cycle pulse in the final cycle of each retired instruction.
REQ-018 illegal  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-019 The block SHALL be a Moore FSM; outputs decode from the state register only, except FETCH/MEMRD/MEMWR strobes and instr_done qualified by mem_ready as stated; any output not listed for a state SHALL be 0.
REQ-020 State encoding SHALL be: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BRANCH=9, JUMP=10, IMMEX=11, IMMWB=12; codes 13-15 SHALL return to IDLE on the next edge.
REQ-021 IDLE: all outputs 0; next state FETCH.
REQ-022 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_ready; hold while mem_ready=0, else go to DECODE.
REQ-023 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; dispatch 000000->EXEC, 100011/101011->MEMADR, 000100->BRANCH, 000010->JUMP, 001000/001101->IMMEX, any other opcode->FETCH with illegal=1.
REQ-024 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, ExtOp=0; lw->MEMRD, sw->MEMWR.
REQ-025 MEMRD: MemRead=1, IorD=1; hold until mem_ready, then go to MEMWB.
REQ-026 MEMWB: RegWrite=1, RegDst=0, MemtoReg=1, instr_done=1; next state FETCH.
REQ-027 MEMWR: MemWrite=1, IorD=1; hold until mem_ready, then go to FETCH with instr_done=1 in that cycle.
REQ-028 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next state RWB.
REQ-029 RWB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1; next state FETCH.
REQ-030 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1; next state FETCH.
REQ-031 JUMP: PCWrite=1, PCSource=10, instr_done=1; next state FETCH.
REQ-032 IMMEX: ALUSrcA=1, ALUSrcB=10; addi gives ALUOp=00, ExtOp=0; ori gives ALUOp=11, ExtOp=1; next state IMMWB.
REQ-033 IMMWB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1; next state FETCH.
REQ-034 Zero-wait cycle counts SHALL be: R-type 4, lw 5, sw 4, beq 3, j 3, addi/ori 4; each mem_ready=0 cycle adds exactly one cycle.
REQ-035 An illegal opcode SHALL assert no RegWrite, MemWrite or PC strobe and SHALL NOT assert instr_done.

Reset
REQ-036 While rst_n=0, state SHALL be IDLE and every output SHALL be 0, independent of clk.
REQ-037 Reset asserted mid-instruction SHALL abort it immediately with no further strobes; after release, the first edge SHALL enter FETCH.

Configuration
REQ-038 With macro MC_JUMP_EN defined, opcode 000010 SHALL dispatch to JUMP; without it, 000010 SHALL be illegal per REQ-035, JUMP SHALL be unreachable, and PCSource SHALL never be 10.

Verification
REQ-039 Release reset, mem_ready=1, opcode=000000 -> states 0,1,2,7,8,1; RegWrite=1 and RegDst=1 only in RWB; instr_done pulses once.
REQ-040 lw with mem_ready low for 2 cycles in MEMRD -> 7 cycles FETCH-to-FETCH; MemtoReg=1 and RegWrite=1 only in MEMWB.
REQ-041 ori (001101) -> IMMEX outputs ALUOp=11 and ExtOp=1; addi outputs ALUOp=00 and ExtOp=0.
REQ-042 opcode=111111 -> DECODE to FETCH, illegal=1 for one cycle, instr_done=0, no write strobes.
REQ-043 rst_n low during MEMWR with mem_ready=0 -> MemWrite drops at once, state=0; resumes at FETCH one edge after release.
REQ-044 opcode=000010 with MC_JUMP_EN defined -> PCWrite=1 and PCSource=10 in JUMP; without the macro -> illegal pulse.

Source files
------------

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath with memory wait states.
// Optional feature: define MC_JUMP_EN to decode opcode 000010 (j) into the JUMP state.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ExtOp,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        RWB    = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10,
        IMMEX  = 4'd11,
        IMMWB  = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        state_d     = IDLE;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ExtOp       = 1'b0;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                state_d = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_RTYPE:       state_d = EXEC;
                    OP_LW, OP_SW:   state_d = MEMADR;
                    OP_BEQ:         state_d = BRANCH;
`ifdef MC_JUMP_EN
                    OP_J:           state_d = JUMP;
`endif
                    OP_ADDI, OP_ORI: state_d = IMMEX;
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
                state_d    = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = RWB;
            end
            RWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
                state_d     = FETCH;
            end
`ifdef MC_JUMP_EN
            JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
`else
            // Unreachable without jump support; treat like an invalid code.
            JUMP: state_d = IDLE;
`endif
            IMMEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (opcode == OP_ORI) begin
                    ALUOp = 2'b11;
                    ExtOp = 1'b1;
                end
                state_d = IMMWB;
            end
            IMMWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
